// File: rtl/motor_ramp_pwm.sv
// Multi-channel motor PWM: shared period counter, per-channel slew-limited duty, emergency stop.
// Define MOTOR_RAMP_EN for slew-rate-limited ramping; otherwise duty jumps to target at each period boundary.
module motor_ramp_pwm #(
    parameter int CHANNELS  = 2,
    parameter int DUTY_W    = 10,
    parameter int PERIOD    = 4000,
    parameter int RAMP_DIV  = 8,
    parameter int RAMP_STEP = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [CHANNELS*DUTY_W-1:0] cmd_duty,
    input  logic                       estop,
    output logic [CHANNELS-1:0]        pwm,
    output logic [CHANNELS*DUTY_W-1:0] cur_duty,
    output logic                       busy,
    output logic                       period_tick
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int MUL_W = DUTY_W + $clog2(PERIOD + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0]    cnt_reg;
    logic [CNT_W-1:0]    cnt_next;
    logic                period_tick_reg;
    logic                boundary;
    logic                step_en;
    logic                transfer;
    logic                clear;
    logic [CHANNELS-1:0] pwm_bits;
    logic [CHANNELS-1:0] differs;

    assign cmd_ready = rst_n & ~estop;
    assign transfer  = cmd_valid & cmd_ready;
    assign clear     = ~rst_n | estop;
    assign boundary  = (cnt_reg == CNT_LAST);
    assign cnt_next  = boundary ? '0 : cnt_reg + CNT_W'(1);

    // Period counter keeps running through estop; only reset stops it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg         <= '0;
            period_tick_reg <= 1'b0;
        end else begin
            cnt_reg         <= cnt_next;
            period_tick_reg <= (cnt_next == CNT_LAST);
        end
    end

`ifdef MOTOR_RAMP_EN
    localparam int RDIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [RDIV_W-1:0] ramp_cnt_reg;
    logic              ramp_last;

    assign ramp_last = (ramp_cnt_reg == RDIV_W'(RAMP_DIV - 1));
    assign step_en   = boundary & ramp_last;

    always_ff @(posedge clk) begin
        if (clear) begin
            ramp_cnt_reg <= '0;
        end else if (boundary) begin
            ramp_cnt_reg <= ramp_last ? '0 : ramp_cnt_reg + RDIV_W'(1);
        end
    end
`else
    logic unused_ramp_cfg;

    assign unused_ramp_cfg = RAMP_DIV[0] ^ RAMP_STEP[0];
    assign step_en         = boundary;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [DUTY_W-1:0] tgt_reg;
            logic [DUTY_W-1:0] cur_reg;
            logic [DUTY_W-1:0] cur_next;
            logic [DUTY_W-1:0] step_val;
            logic [CNT_W-1:0]  thr_reg;
            logic [CNT_W-1:0]  thr_next;
            logic [MUL_W-1:0]  product;
            logic              pwm_reg;

`ifdef MOTOR_RAMP_EN
            // Clamp the step so the DUTY_W+1-bit sum/difference can never wrap.
            localparam int STEP_CLAMP = (RAMP_STEP > (1 << DUTY_W)) ? (1 << DUTY_W) : RAMP_STEP;
            localparam logic [DUTY_W:0] STEP_EXT = (DUTY_W + 1)'(STEP_CLAMP);

            logic [DUTY_W:0] up_sum;
            logic [DUTY_W:0] dn_diff;

            always_comb begin
                up_sum   = {1'b0, cur_reg} + STEP_EXT;
                dn_diff  = {1'b0, cur_reg} - STEP_EXT;
                step_val = cur_reg;
                if (cur_reg < tgt_reg) begin
                    step_val = (up_sum > {1'b0, tgt_reg}) ? tgt_reg : up_sum[DUTY_W-1:0];
                end else if (cur_reg > tgt_reg) begin
                    // MSB set means cur - step went negative.
                    step_val = (dn_diff[DUTY_W] || (dn_diff < {1'b0, tgt_reg})) ? tgt_reg
                                                                               : dn_diff[DUTY_W-1:0];
                end
            end
`else
            assign step_val = tgt_reg;
`endif

            // Threshold is derived from the next duty so both registers change on the same edge.
            always_comb begin
                cur_next = step_en ? step_val : cur_reg;
                product  = MUL_W'(cur_next) * MUL_W'(PERIOD);
                thr_next = CNT_W'(product >> DUTY_W);
            end

            always_ff @(posedge clk) begin
                if (clear) begin
                    tgt_reg <= '0;
                    cur_reg <= '0;
                    thr_reg <= '0;
                    pwm_reg <= 1'b0;
                end else begin
                    if (transfer) begin
                        tgt_reg <= cmd_duty[gi*DUTY_W +: DUTY_W];
                    end
                    cur_reg <= cur_next;
                    thr_reg <= thr_next;
                    pwm_reg <= (cnt_reg < thr_reg);
                end
            end

            assign pwm_bits[gi]                  = pwm_reg;
            assign differs[gi]                   = (cur_reg != tgt_reg);
            assign cur_duty[gi*DUTY_W +: DUTY_W] = cur_reg;
        end
    endgenerate

    assign pwm         = pwm_bits;
    assign busy        = |differs;
    assign period_tick = period_tick_reg;

endmodule

// File: tb/tb_motor_ramp_pwm.sv
// Bench for motor_ramp_pwm: cycle-level arithmetic model plus directed scenarios with literal pins.
// Expected literals follow MOTOR_RAMP_EN the same way the design does.
module tb_motor_ramp_pwm;

    localparam int CH    = 2;
    localparam int DW    = 4;
    localparam int PER   = 16;
    localparam int RDIV  = 2;
    localparam int RSTEP = 4;

`ifdef MOTOR_RAMP_EN
    localparam logic [7:0] E_S2_B1 = 8'h00, E_S2_B2 = 8'h44, E_S2_B4 = 8'h88;
    localparam logic [7:0] E_S3_B8 = 8'h88, E_S3_B10 = 8'h84;
    localparam logic [7:0] E_S4_B14 = 8'h86;
    localparam int         E_S4_HI0 = 6;
    localparam logic [7:0] E_S7_B2 = 8'h44;
`else
    localparam logic [7:0] E_S2_B1 = 8'h8C, E_S2_B2 = 8'h8C, E_S2_B4 = 8'h8C;
    localparam logic [7:0] E_S3_B8 = 8'h82, E_S3_B10 = 8'h82;
    localparam logic [7:0] E_S4_B14 = 8'h8F;
    localparam int         E_S4_HI0 = 15;
    localparam logic [7:0] E_S7_B2 = 8'h8C;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [CH*DW-1:0] cmd_duty;
    logic          estop;
    logic [CH-1:0] pwm;
    logic [CH*DW-1:0] cur_duty;
    logic          busy;
    logic          period_tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    motor_ramp_pwm #(
        .CHANNELS (CH),
        .DUTY_W   (DW),
        .PERIOD   (PER),
        .RAMP_DIV (RDIV),
        .RAMP_STEP(RSTEP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_duty   (cmd_duty),
        .estop      (estop),
        .pwm        (pwm),
        .cur_duty   (cur_duty),
        .busy       (busy),
        .period_tick(period_tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_cnt, m_ramp;
    int          m_tgt[CH];
    int          m_cur[CH];
    int          m_old[CH];
    logic [CH-1:0] m_pwm;
    logic        m_tick;
    bit          model_on = 1'b0;

    function automatic int thr_of(input int d);
        return (d * PER) / (1 << DW);
    endfunction

    function automatic int step_toward(input int c, input int t);
        if (c < t) return (c + RSTEP > t) ? t : c + RSTEP;
        if (c > t) return (c - RSTEP < t) ? t : c - RSTEP;
        return c;
    endfunction

    initial begin : model
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_cnt  = 0;
                m_ramp = 0;
                for (int i = 0; i < CH; i++) begin
                    m_tgt[i] = 0;
                    m_cur[i] = 0;
                end
                m_pwm    = '0;
                m_tick   = 1'b0;
                model_on = 1'b1;
            end else begin
                for (int i = 0; i < CH; i++)
                    m_pwm[i] = estop ? 1'b0 : (m_cnt < thr_of(m_cur[i]));
                if (estop) begin
                    m_ramp = 0;
                    for (int i = 0; i < CH; i++) begin
                        m_tgt[i] = 0;
                        m_cur[i] = 0;
                    end
                end else begin
                    m_old = m_tgt;
                    if (cmd_valid)
                        for (int i = 0; i < CH; i++) m_tgt[i] = int'(cmd_duty[i*DW +: DW]);
                    if (m_cnt == PER - 1) begin
`ifdef MOTOR_RAMP_EN
                        if (m_ramp == RDIV - 1) begin
                            for (int i = 0; i < CH; i++) m_cur[i] = step_toward(m_cur[i], m_old[i]);
                            m_ramp = 0;
                        end else begin
                            m_ramp = m_ramp + 1;
                        end
`else
                        m_cur = m_old;
`endif
                    end
                end
                m_cnt  = (m_cnt + 1) % PER;
                m_tick = (m_cnt == PER - 1);
            end
        end
    end

    // Every-cycle comparison against the model, sampled mid-low-phase.
    initial begin : compare
        logic [CH*DW-1:0] e_cur;
        logic             e_busy;
        forever begin
            @(negedge clk);
            #2;
            if (model_on) begin
                e_busy = 1'b0;
                for (int i = 0; i < CH; i++) begin
                    e_cur[i*DW +: DW] = m_cur[i][DW-1:0];
                    if (m_cur[i] != m_tgt[i]) e_busy = 1'b1;
                end
                check("cyc_pwm", 32'(pwm), 32'(m_pwm));
                check("cyc_cur_duty", 32'(cur_duty), 32'(e_cur));
                check("cyc_busy", 32'(busy), 32'(e_busy));
                check("cyc_period_tick", 32'(period_tick), 32'(m_tick));
                check("cyc_cmd_ready", 32'(cmd_ready), 32'(rst_n & ~estop));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_boundary();
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 2 * PER) begin
            @(negedge clk);
            n++;
            if (period_tick === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL boundary_wait: no period_tick within %0d cycles", 2 * PER);
        end
        @(negedge clk);
    endtask

    task automatic count_pwm(output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < PER; i++) begin
            @(negedge clk);
            if (pwm[0] === 1'b1) c0++;
            if (pwm[1] === 1'b1) c1++;
        end
    endtask

    task automatic send(input logic [CH*DW-1:0] d);
        cmd_duty  = d;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int ticks, hi, c0, c1;
        rst_n     = 1'b0;
        estop     = 1'b0;
        cmd_valid = 1'b0;
        cmd_duty  = '0;
        repeat (3) @(negedge clk);
        check("rst_pwm", 32'(pwm), 32'h0);
        check("rst_cur_duty", 32'(cur_duty), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_period_tick", 32'(period_tick), 32'h0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        rst_n = 1'b1;

        // Idle: no command for 64 cycles
        ticks = 0;
        hi    = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (period_tick === 1'b1) ticks++;
            if (pwm !== 2'b00) hi++;
        end
        check("s1_tick_count", 32'(ticks), 32'd4);
        check("s1_pwm_nonzero", 32'(hi), 32'd0);
        check("s1_busy", 32'(busy), 32'h0);

        // Ramp up: ch0 -> 12, ch1 -> 8
        send({4'd8, 4'd12});
        check("s2_busy_on", 32'(busy), 32'h1);
        next_boundary();
        check("s2_b1_cur", 32'(cur_duty), 32'(E_S2_B1));
        next_boundary();
        check("s2_b2_cur", 32'(cur_duty), 32'(E_S2_B2));
        repeat (2) next_boundary();
        check("s2_b4_cur", 32'(cur_duty), 32'(E_S2_B4));
        repeat (2) next_boundary();
        check("s2_b6_cur", 32'(cur_duty), 32'h8C);
        check("s2_b6_busy", 32'(busy), 32'h0);
        count_pwm(c0, c1);
        check("s2_pwm0_high", 32'(c0), 32'd12);
        check("s2_pwm1_high", 32'(c1), 32'd8);

        // Ramp down: ch0 -> 2, ch1 unchanged
        send({4'd8, 4'd2});
        next_boundary();
        check("s3_b8_cur", 32'(cur_duty), 32'(E_S3_B8));
        repeat (2) next_boundary();
        check("s3_b10_cur", 32'(cur_duty), 32'(E_S3_B10));
        repeat (2) next_boundary();
        check("s3_b12_cur", 32'(cur_duty), 32'h82);
        check("s3_b12_busy", 32'(busy), 32'h0);
        count_pwm(c0, c1);
        check("s3_pwm0_high", 32'(c0), 32'd2);
        check("s3_pwm1_high", 32'(c1), 32'd8);

        // Mid-period command change: this period's width must not change
        hi = 0;
        for (int i = 0; i < PER; i++) begin
            if (i == 5) begin
                cmd_duty  = {4'd8, 4'd15};
                cmd_valid = 1'b1;
            end
            if (i == 6) cmd_valid = 1'b0;
            @(negedge clk);
            if (pwm[0] === 1'b1) hi++;
        end
        check("s4_no_glitch_high", 32'(hi), 32'd2);
        check("s4_b14_cur", 32'(cur_duty), 32'(E_S4_B14));
        count_pwm(c0, c1);
        check("s4_pwm0_high", 32'(c0), 32'(E_S4_HI0));

        // Emergency stop for 3 cycles
        repeat (3) @(negedge clk);
        estop = 1'b1;
        @(negedge clk);
        check("s5_estop_pwm", 32'(pwm), 32'h0);
        check("s5_estop_cur", 32'(cur_duty), 32'h0);
        check("s5_estop_ready", 32'(cmd_ready), 32'h0);
        repeat (2) @(negedge clk);
        estop = 1'b0;
        @(negedge clk);
        check("s5_release_ready", 32'(cmd_ready), 32'h1);
        repeat (2) next_boundary();
        check("s5_after_cur", 32'(cur_duty), 32'h0);
        check("s5_after_busy", 32'(busy), 32'h0);

        // Reset pulse mid-ramp, then ramp restarts from zero
        send({4'd8, 4'd12});
        repeat (2) next_boundary();
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("s7_rst_cur", 32'(cur_duty), 32'h0);
        check("s7_rst_pwm", 32'(pwm), 32'h0);
        check("s7_rst_busy", 32'(busy), 32'h0);
        check("s7_rst_tick", 32'(period_tick), 32'h0);
        check("s7_rst_ready", 32'(cmd_ready), 32'h0);
        rst_n = 1'b1;
        send({4'd8, 4'd12});
        repeat (2) next_boundary();
        check("s7_b2_cur", 32'(cur_duty), 32'(E_S7_B2));

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
